// File: rtl/pipe_ctrl_if.sv
// Bundle of the pipeline-control signals that run between the pipeline
// stages and the sequencing controller. The pipeline side is the master
// (it raises requests and consumes the hold vector); the controller is the slave.
interface pipe_ctrl_if #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 16
);
  // requests from the pipeline stages
  logic              stallreq_from_if;
  logic              stallreq_from_id;
  logic              stallreq_from_ex;
  logic              stallreq_from_mem;
  logic              ex_multi_start;
  logic [CNT_W-1:0]  ex_multi_cycles;
  logic              flush_req;
  logic [31:0]       flush_pc;
  logic              perf_clr;
  // controller responses
  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              busy;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output ex_multi_start, ex_multi_cycles, flush_req, flush_pc, perf_clr,
    input  stall, flush, new_pc, busy, stall_cycles
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  ex_multi_start, ex_multi_cycles, flush_req, flush_pc, perf_clr,
    output stall, flush, new_pc, busy, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the five-stage OpenMIPS core.
// Merges per-stage stall requests into a hold vector, sequences multi-cycle
// EX operations (madd/msub, div) with a down-counter, turns an exception
// request into a registered one-cycle flush with redirect PC, and counts
// stalled cycles in a saturating performance counter.
module pipe_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 16
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULTI = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [5:0] HOLD_NONE = 6'b000000;
  localparam logic [5:0] HOLD_IF   = 6'b000011;
  localparam logic [5:0] HOLD_ID   = 6'b000111;
  localparam logic [5:0] HOLD_EX   = 6'b001111;
  localparam logic [5:0] HOLD_MEM  = 6'b011111;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PERF_W-1:0] PERF_ZERO = {PERF_W{1'b0}};
  localparam logic [PERF_W-1:0] PERF_ONE  = {{(PERF_W-1){1'b0}}, 1'b1};
  localparam logic [PERF_W-1:0] PERF_MAX  = {PERF_W{1'b1}};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              flush_r;
  logic [31:0]       new_pc_r;
  logic [PERF_W-1:0] perf_r;
  logic [5:0]        stall_s;
  logic              start_stall_s;
  logic              start_long_s;

  // A start only counts in IDLE; K = 0 is a no-op, K >= 2 needs the MULTI state.
  assign start_stall_s = (state_r == ST_IDLE) && bus.ex_multi_start &&
                         (bus.ex_multi_cycles != CNT_ZERO);
  assign start_long_s  = start_stall_s && (bus.ex_multi_cycles != CNT_ONE);

  // Hold vector: deepest requesting stage wins; nothing is held during a flush or reset.
  always_comb begin
    stall_s = HOLD_NONE;
    if (rst || (state_r == ST_FLUSH)) begin
      stall_s = HOLD_NONE;
    end else if (bus.stallreq_from_mem) begin
      stall_s = HOLD_MEM;
    end else if (bus.stallreq_from_ex || (state_r == ST_MULTI) || start_stall_s) begin
      stall_s = HOLD_EX;
    end else if (bus.stallreq_from_id) begin
      stall_s = HOLD_ID;
    end else if (bus.stallreq_from_if) begin
      stall_s = HOLD_IF;
    end else begin
      stall_s = HOLD_NONE;
    end
  end

  // Next-state logic: flush overrides everything, aborting any multi-cycle op.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (bus.flush_req) begin
      state_nxt_s = ST_FLUSH;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_long_s) begin
            // the start cycle itself is the first of K stalled cycles
            state_nxt_s = ST_MULTI;
            cnt_nxt_s   = bus.ex_multi_cycles - CNT_ONE;
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end
        end
        ST_MULTI: begin
          // keeps counting even while MEM holds the pipe
          if (cnt_r <= CNT_ONE) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = ST_MULTI;
            cnt_nxt_s   = cnt_r - CNT_ONE;
          end
        end
        ST_FLUSH: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and multi-cycle counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Registered flush pulse and redirect PC; the PC is held between flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_r  <= 1'b0;
      new_pc_r <= 32'h0000_0000;
    end else begin
      flush_r <= bus.flush_req;
      if (bus.flush_req) begin
        new_pc_r <= bus.flush_pc;
      end else begin
        new_pc_r <= new_pc_r;
      end
    end
  end

  // Saturating count of cycles in which the PC is held; clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_r <= PERF_ZERO;
    end else if (bus.perf_clr) begin
      perf_r <= PERF_ZERO;
    end else if (stall_s[0] && (perf_r != PERF_MAX)) begin
      perf_r <= perf_r + PERF_ONE;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign bus.stall        = stall_s;
  assign bus.flush        = flush_r;
  assign bus.new_pc       = new_pc_r;
  assign bus.busy         = (state_r == ST_MULTI);
  assign bus.stall_cycles = perf_r;

endmodule
